// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a valid/ready write port feeds a FIFO that is drained
// LSB-first onto o_tx_serial, with frames sent back-to-back while i_tx_en is high.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          sysclk,
    input  logic                          rst_n,
    input  logic                          i_tx_en,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    output logic                          o_tx_serial,
    output logic                          o_tx_busy,
    output logic                          o_tx_d,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic [BW-1:0]         baud_cnt;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  push, pop, baud_done, can_pop;

    assign o_wr_ready   = (count != FULL);
    assign o_fifo_count = count;
    assign o_tx_busy    = (state != IDLE);
    assign push         = i_wr_valid & o_wr_ready;
    assign baud_done    = (baud_cnt == BAUD_LAST);
    assign can_pop      = i_tx_en && (count != '0);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Popping is tied to START entry so the head byte lands in the shifter on that edge.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (can_pop) begin
                    state_nxt = START;
                    pop       = 1'b1;
                end
            end
            START: begin
                if (baud_done) state_nxt = DATA;
            end
            DATA: begin
                if (baud_done && bit_idx == BIT_LAST) state_nxt = STOP;
            end
            STOP: begin
                if (baud_done) begin
                    if (can_pop) begin
                        state_nxt = START;
                        pop       = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_tx_serial = 1'b1;
        unique case (state)
            START:   o_tx_serial = 1'b0;
            DATA:    o_tx_serial = shift[0];
            default: o_tx_serial = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    // Baud counter restarts on every state entry so back-to-back frames never drift.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            o_tx_d   <= 1'b0;
        end else begin
            o_tx_d <= (state == STOP) && baud_done;
            if (state == IDLE || baud_done || state_nxt != state) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
            if (pop) begin
                shift   <= mem[rd_ptr];
                bit_idx <= '0;
            end else if (state == DATA && baud_done) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at CLKS_PER_BIT=4: a line recorder captures every
// frame, and tests compare it against frames built from the bytes the bench queued.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       i_tx_en;
    logic [7:0] i_wr_data;
    logic       i_wr_valid;
    logic       o_wr_ready, o_tx_serial, o_tx_busy, o_tx_d;
    logic [4:0] o_fifo_count;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    logic [FRAME-1:0] fr_v[$];
    int unsigned      fr_s[$];
    int unsigned      txd_q[$];
    logic [7:0]       exp_q[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .i_tx_en(i_tx_en), .i_wr_data(i_wr_data),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .o_tx_serial(o_tx_serial),
        .o_tx_busy(o_tx_busy), .o_tx_d(o_tx_d), .o_fifo_count(o_fifo_count)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Line recorder: a frame is the 40 samples starting at the first low after idle.
    initial begin : recorder
        logic [FRAME-1:0] v;
        int unsigned t, s;
        bit on;
        on = 0; t = 0; s = 0; v = '1;
        forever begin
            @(negedge sysclk);
            if (o_tx_d) txd_q.push_back(cyc);
            if (!rst_n) begin
                on = 0;
            end else if (!on) begin
                if (!o_tx_serial) begin
                    on = 1; t = 1; v = '1; v[0] = 1'b0; s = cyc;
                end
            end else begin
                v[t] = o_tx_serial;
                t++;
                if (t == FRAME) begin
                    fr_v.push_back(v);
                    fr_s.push_back(s);
                    on = 0;
                end
            end
        end
    end

    // Expected line for one byte: 1 start bit low, 8 data bits LSB first, 1 stop bit high.
    function automatic logic [FRAME-1:0] frame_of(input logic [7:0] b);
        logic [FRAME-1:0] v;
        for (int t = 0; t < FRAME; t++) begin
            int idx;
            idx = t / CPB;
            if (idx == 0)      v[t] = 1'b0;
            else if (idx == 9) v[t] = 1'b1;
            else               v[t] = b[idx-1];
        end
        return v;
    endfunction

    task automatic clear_logs();
        fr_v.delete(); fr_s.delete(); txd_q.delete(); exp_q.delete();
    endtask

    // Offers b until accepted; returns #1 after the accepting edge with valid still high.
    task automatic push_byte(input logic [7:0] b, output int unsigned acc);
        bit ok;
        i_wr_valid = 1'b1;
        i_wr_data  = b;
        acc = 0;
        for (int n = 0; n < 3000; n++) begin
            ok = o_wr_ready;
            @(posedge sysclk); #1;
            if (ok) begin
                acc = cyc;
                exp_q.push_back(b);
                return;
            end
        end
        total++; bad++;
        $display("FAIL push_timeout: byte %02h not accepted, required acceptance within 3000 clk", b);
    endtask

    task automatic wait_frames(input int unsigned n, input int unsigned budget);
        int unsigned k;
        k = 0;
        while (fr_v.size() < n && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        if (fr_v.size() < n) begin
            total++; bad++;
            $display("FAIL frame_timeout: got %0d frames, required %0d", fr_v.size(), n);
        end
        repeat (3) @(negedge sysclk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_tx_en = 1'b0; i_wr_valid = 1'b0; i_wr_data = '0;
        repeat (3) @(negedge sysclk);
        total += 5;
        if (o_tx_serial !== 1'b1) begin bad++; $display("FAIL reset_serial: got %b, required 1", o_tx_serial); end
        if (o_tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", o_tx_busy); end
        if (o_tx_d !== 1'b0) begin bad++; $display("FAIL reset_txd: got %b, required 0", o_tx_d); end
        if (o_fifo_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d, required 0", o_fifo_count); end
        if (o_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b, required 1", o_wr_ready); end
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);
    endtask

    task automatic test_single(input logic [7:0] b);
        int unsigned k;
        clear_logs();
        i_tx_en = 1'b1;
        @(negedge sysclk);
        push_byte(b, k);
        i_wr_valid = 1'b0;
        total++;
        if (o_fifo_count !== 5'd1) begin bad++; $display("FAIL single_count_after_push: got %0d, required 1", o_fifo_count); end
        wait_frames(1, 80);
        if (fr_v.size() >= 1) begin
            total += 2;
            if (fr_v[0] !== frame_of(b)) begin bad++; $display("FAIL single_frame_%02h: got %h, required %h", b, fr_v[0], frame_of(b)); end
            if (fr_s[0] !== k + 1) begin bad++; $display("FAIL single_latency: start at %0d, required %0d", fr_s[0], k + 1); end
            total += 2;
            if (txd_q.size() !== 1) begin bad++; $display("FAIL single_txd_pulses: got %0d, required 1", txd_q.size()); end
            else if (txd_q[0] !== fr_s[0] + FRAME) begin bad++; $display("FAIL single_txd_time: got %0d, required %0d", txd_q[0], fr_s[0] + FRAME); end
        end
        total += 2;
        if (o_fifo_count !== 5'd0) begin bad++; $display("FAIL single_count_end: got %0d, required 0", o_fifo_count); end
        if (o_tx_busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b, required 0", o_tx_busy); end
    endtask

    task automatic test_fill();
        int unsigned k;
        logic [7:0] b17;
        clear_logs();
        i_tx_en = 1'b0;
        @(negedge sysclk);
        for (int i = 0; i < 16; i++) push_byte(8'($urandom), k);
        b17 = 8'($urandom);
        i_wr_data = b17;
        repeat (3) @(negedge sysclk);
        total += 4;
        if (o_wr_ready !== 1'b0) begin bad++; $display("FAIL fill_ready: got %b, required 0", o_wr_ready); end
        if (o_fifo_count !== 5'd16) begin bad++; $display("FAIL fill_count: got %0d, required 16", o_fifo_count); end
        if (o_tx_serial !== 1'b1) begin bad++; $display("FAIL fill_serial: got %b, required 1", o_tx_serial); end
        if (fr_v.size() !== 0) begin bad++; $display("FAIL fill_no_frame: got %0d frames, required 0", fr_v.size()); end
        i_tx_en = 1'b1;
        @(posedge sysclk);
        @(posedge sysclk); #1;
        exp_q.push_back(b17);
        i_wr_valid = 1'b0;
        total++;
        if (o_fifo_count !== 5'd16) begin bad++; $display("FAIL fill_refill_count: got %0d, required 16", o_fifo_count); end
        wait_frames(17, 17 * FRAME + 50);
        for (int i = 0; i < 17 && i < fr_v.size(); i++) begin
            total++;
            if (fr_v[i] !== frame_of(exp_q[i])) begin bad++; $display("FAIL fill_frame_%0d: got %h, required %h", i, fr_v[i], frame_of(exp_q[i])); end
            if (i > 0) begin
                total++;
                if (fr_s[i] - fr_s[i-1] !== FRAME) begin bad++; $display("FAIL fill_gap_%0d: got %0d, required %0d", i, fr_s[i] - fr_s[i-1], FRAME); end
            end
        end
        total++;
        if (o_fifo_count !== 5'd0) begin bad++; $display("FAIL fill_drained: got %0d, required 0", o_fifo_count); end
    endtask

    task automatic test_back_to_back();
        int unsigned k, k0, lows;
        logic [7:0] pat [3];
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h3C;
        clear_logs();
        i_tx_en = 1'b1;
        @(negedge sysclk);
        push_byte(pat[0], k0);
        push_byte(pat[1], k);
        push_byte(pat[2], k);
        i_wr_valid = 1'b0;
        lows = 0;
        while (cyc <= k0 + 3 * FRAME) begin
            @(negedge sysclk);
            if (cyc <= k0 + 3 * FRAME && !o_tx_busy) lows++;
        end
        total += 2;
        if (lows !== 0) begin bad++; $display("FAIL b2b_busy: busy low %0d cycles, required 0", lows); end
        if (o_tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b, required 0", o_tx_busy); end
        wait_frames(3, 50);
        for (int i = 0; i < 3 && i < fr_v.size(); i++) begin
            total += 2;
            if (fr_v[i] !== frame_of(pat[i])) begin bad++; $display("FAIL b2b_frame_%0d: got %h, required %h", i, fr_v[i], frame_of(pat[i])); end
            if (fr_s[i] !== k0 + 1 + i * FRAME) begin bad++; $display("FAIL b2b_start_%0d: got %0d, required %0d", i, fr_s[i], k0 + 1 + i * FRAME); end
        end
        total++;
        if (txd_q.size() !== 3) begin
            bad++; $display("FAIL b2b_txd_pulses: got %0d, required 3", txd_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (txd_q[i] !== k0 + 1 + (i + 1) * FRAME) begin bad++; $display("FAIL b2b_txd_%0d: got %0d, required %0d", i, txd_q[i], k0 + 1 + (i + 1) * FRAME); end
            end
        end
    endtask

    task automatic test_enable_drop();
        int unsigned k0, k, r;
        clear_logs();
        i_tx_en = 1'b1;
        @(negedge sysclk);
        push_byte(8'($urandom), k0);
        push_byte(8'($urandom), k);
        i_wr_valid = 1'b0;
        while (cyc < k0 + 1 + 10) @(negedge sysclk);
        i_tx_en = 1'b0;
        while (cyc < k0 + 1 + FRAME + 2) @(negedge sysclk);
        total += 3;
        if (o_tx_busy !== 1'b0) begin bad++; $display("FAIL drop_busy: got %b, required 0", o_tx_busy); end
        if (o_fifo_count !== 5'd1) begin bad++; $display("FAIL drop_count: got %0d, required 1", o_fifo_count); end
        if (fr_v.size() !== 1) begin bad++; $display("FAIL drop_frames: got %0d, required 1", fr_v.size()); end
        repeat ($urandom_range(3, 10)) @(negedge sysclk);
        total++;
        if (o_tx_serial !== 1'b1) begin bad++; $display("FAIL drop_idle_line: got %b, required 1", o_tx_serial); end
        i_tx_en = 1'b1;
        @(posedge sysclk); #1;
        r = cyc;
        wait_frames(2, 2 * FRAME + 20);
        if (fr_v.size() >= 2) begin
            total += 3;
            if (fr_v[0] !== frame_of(exp_q[0])) begin bad++; $display("FAIL drop_frame0: got %h, required %h", fr_v[0], frame_of(exp_q[0])); end
            if (fr_v[1] !== frame_of(exp_q[1])) begin bad++; $display("FAIL drop_frame1: got %h, required %h", fr_v[1], frame_of(exp_q[1])); end
            if (fr_s[1] !== r) begin bad++; $display("FAIL drop_restart: got %0d, required %0d", fr_s[1], r); end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned k0, k;
        clear_logs();
        i_tx_en = 1'b1;
        @(negedge sysclk);
        push_byte(8'($urandom), k0);
        push_byte(8'($urandom), k);
        i_wr_valid = 1'b0;
        while (cyc < k0 + 1 + 4 * CPB + 1) @(negedge sysclk);
        rst_n = 1'b0;
        #1;
        total += 3;
        if (o_tx_serial !== 1'b1) begin bad++; $display("FAIL rstmid_serial: got %b, required 1", o_tx_serial); end
        if (o_tx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b, required 0", o_tx_busy); end
        if (o_fifo_count !== 5'd0) begin bad++; $display("FAIL rstmid_count: got %0d, required 0", o_fifo_count); end
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        fr_v.delete(); fr_s.delete();
        repeat (3 * FRAME) @(negedge sysclk);
        total += 2;
        if (fr_v.size() !== 0) begin bad++; $display("FAIL rstmid_no_frame: got %0d frames, required 0", fr_v.size()); end
        if (o_tx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle: busy %b, required 0", o_tx_busy); end
    endtask

    task automatic test_push_pop();
        int unsigned k;
        clear_logs();
        i_tx_en = 1'b0;
        @(negedge sysclk);
        for (int i = 0; i < 3; i++) push_byte(8'($urandom), k);
        i_wr_valid = 1'b0;
        @(negedge sysclk);
        total++;
        if (o_fifo_count !== 5'd3) begin bad++; $display("FAIL pp_count_before: got %0d, required 3", o_fifo_count); end
        i_tx_en = 1'b1;
        push_byte(8'($urandom), k);
        i_wr_valid = 1'b0;
        total += 2;
        if (o_fifo_count !== 5'd3) begin bad++; $display("FAIL pp_count_same_edge: got %0d, required 3", o_fifo_count); end
        if (o_tx_busy !== 1'b1) begin bad++; $display("FAIL pp_busy: got %b, required 1", o_tx_busy); end
        wait_frames(4, 4 * FRAME + 20);
        for (int i = 0; i < 4 && i < fr_v.size(); i++) begin
            total++;
            if (fr_v[i] !== frame_of(exp_q[i])) begin bad++; $display("FAIL pp_frame_%0d: got %h, required %h", i, fr_v[i], frame_of(exp_q[i])); end
        end
    endtask

    task automatic test_random();
        int unsigned k, n;
        for (int round = 0; round < 3; round++) begin
            clear_logs();
            i_tx_en = 1'b1;
            n = $urandom_range(2, 6);
            @(negedge sysclk);
            for (int i = 0; i < n; i++) begin
                i_wr_valid = 1'b0;
                repeat ($urandom_range(0, 45)) @(negedge sysclk);
                push_byte(8'($urandom), k);
            end
            i_wr_valid = 1'b0;
            wait_frames(n, n * FRAME + 60);
            total++;
            if (fr_v.size() !== n) begin bad++; $display("FAIL rand_count_r%0d: got %0d frames, required %0d", round, fr_v.size(), n); end
            for (int i = 0; i < n && i < fr_v.size(); i++) begin
                total++;
                if (fr_v[i] !== frame_of(exp_q[i])) begin bad++; $display("FAIL rand_frame_r%0d_%0d: got %h, required %h", round, i, fr_v[i], frame_of(exp_q[i])); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single(8'hA5);
        test_single(8'($urandom));
        test_fill();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_push_pop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
